// File: rtl/rx_frame_packer_pkg.sv
// Shared defaults and slot-index helper for rx_frame_packer.
// Fallback widths apply when param_def.v has not already defined them.
`ifndef MAX_CODE_RATE
`define MAX_CODE_RATE 2
`endif
`ifndef TRACEBACK_DEPTH
`define TRACEBACK_DEPTH 16
`endif
`ifndef RX_PACKER_SYMS
`define RX_PACKER_SYMS (`TRACEBACK_DEPTH/`MAX_CODE_RATE)
`endif

package rx_frame_packer_pkg;

    localparam int DEF_SYM_W   = `MAX_CODE_RATE;
    localparam int DEF_FRAME_W = `TRACEBACK_DEPTH;

    typedef logic buf_sel_t;

    // Symbols are packed MSB-first, so slot k starts at the top of the frame.
    function automatic int slot_msb(input int frame_w, input int sym_w, input int slot);
        return frame_w - 1 - slot * sym_w;
    endfunction

endpackage

// File: rtl/rx_frame_packer.sv
// Ping-pong receive frame assembler feeding the decoder.
// Optional RX_PACKER_STATS_EN adds a drained-frame counter and a sticky stall flag.
module rx_frame_packer
    import rx_frame_packer_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int FRAME_W = DEF_FRAME_W,
    localparam int SYMS   = FRAME_W / SYM_W,
    localparam int PAD_W  = $clog2(SYMS + 1)
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [SYM_W-1:0]   i_sym,
    input  logic               i_sym_valid,
    output logic               o_sym_ready,
    input  logic               i_flush,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_valid,
    input  logic               i_frame_ready,
    output logic [PAD_W-1:0]   o_pad_syms
`ifdef RX_PACKER_STATS_EN
    ,
    output logic [15:0]        o_frame_cnt,
    output logic [0:0]         o_stall
`endif
);

    localparam int CNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;

    logic [FRAME_W-1:0] buf_q [2];
    logic [PAD_W-1:0]   pad_q [2];
    logic [1:0]         full_q;
    buf_sel_t           wr_sel;
    buf_sel_t           rd_sel;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               close;
    logic               drain;
    logic [CNT_W:0]     held;
    logic [FRAME_W-1:0] wr_next;
    logic [PAD_W-1:0]   pad_next;

    assign o_sym_ready   = !full_q[wr_sel];
    assign accept        = i_sym_valid && o_sym_ready;
    assign held          = {1'b0, cnt} + (CNT_W + 1)'(accept);
    assign close         = (accept && (cnt == CNT_W'(SYMS - 1)))
                           || (i_flush && o_sym_ready && (held != '0));
    assign drain         = full_q[rd_sel] && i_frame_ready;

    assign o_frame       = buf_q[rd_sel];
    assign o_frame_valid = full_q[rd_sel];
    assign o_pad_syms    = pad_q[rd_sel];

    // One index calculation serves whichever buffer is currently being filled.
    always_comb begin
        wr_next  = buf_q[wr_sel];
        pad_next = PAD_W'(SYMS - int'(held));
        if (accept) begin
            wr_next[slot_msb(FRAME_W, SYM_W, int'(cnt)) -: SYM_W] = i_sym;
        end
        if (close) begin
            for (int k = 0; k < SYMS; k++) begin
                if (k >= int'(held)) begin
                    wr_next[slot_msb(FRAME_W, SYM_W, k) -: SYM_W] = '0;
                end
            end
        end
    end

    // A close and a drain always target different buffers, so both may land together.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            pad_q[0] <= '0;
            pad_q[1] <= '0;
            full_q   <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (accept || close) begin
                buf_q[wr_sel] <= wr_next;
            end
            if (drain) begin
                full_q[rd_sel] <= 1'b0;
                rd_sel         <= ~rd_sel;
            end
            if (close) begin
                full_q[wr_sel] <= 1'b1;
                pad_q[wr_sel]  <= pad_next;
                wr_sel         <= ~wr_sel;
                cnt            <= '0;
            end else if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef RX_PACKER_STATS_EN
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            o_frame_cnt <= '0;
            o_stall     <= 1'b0;
        end else begin
            if (drain) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (i_sym_valid && !o_sym_ready) begin
                o_stall <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_packer.sv
// Randomized self-checking bench for rx_frame_packer with a queue-based frame model.
// Stats checks are compiled in when RX_PACKER_STATS_EN is defined.
module tb_rx_frame_packer;

    localparam int SYM_W   = 2;
    localparam int FRAME_W = 16;
    localparam int SYMS    = 8;
    localparam int PAD_W   = $clog2(SYMS + 1);

    logic               sys_clk = 1'b0;
    logic               rst;
    logic [SYM_W-1:0]   i_sym;
    logic               i_sym_valid;
    logic               o_sym_ready;
    logic               i_flush;
    logic [FRAME_W-1:0] o_frame;
    logic               o_frame_valid;
    logic               i_frame_ready;
    logic [PAD_W-1:0]   o_pad_syms;
`ifdef RX_PACKER_STATS_EN
    logic [15:0]        o_frame_cnt;
    logic [0:0]         o_stall;
`endif

    rx_frame_packer #(.SYM_W(SYM_W), .FRAME_W(FRAME_W)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .i_sym         (i_sym),
        .i_sym_valid   (i_sym_valid),
        .o_sym_ready   (o_sym_ready),
        .i_flush       (i_flush),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_pad_syms    (o_pad_syms)
`ifdef RX_PACKER_STATS_EN
        ,
        .o_frame_cnt   (o_frame_cnt),
        .o_stall       (o_stall)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [FRAME_W-1:0] frame;
        int                 pad;
    } exp_frame_t;

    // Model: symbols of the frame in progress, plus completed frames awaiting the decoder.
    int         cur_syms[$];
    exp_frame_t pend[$];
    int         exp_frame_cnt;
    bit         exp_stall;
    int         checks;
    int         errors;

    function automatic exp_frame_t build_frame(input int pad);
        exp_frame_t f;
        f.frame = '0;
        foreach (cur_syms[k]) begin
            f.frame = f.frame | (16'(cur_syms[k]) << (FRAME_W - SYM_W * (k + 1)));
        end
        f.pad = pad;
        return f;
    endfunction

    task automatic model_clear();
        cur_syms.delete();
        pend.delete();
        exp_frame_cnt = 0;
        exp_stall     = 1'b0;
    endtask

    // Called at a falling edge; drives one cycle and advances the model across the rising edge.
    task automatic drive_cycle(input bit v, input int s, input bit fl, input bit rdy);
        bit acc;
        bit drn;
        i_sym_valid   = v;
        i_sym         = SYM_W'(s);
        i_flush       = fl;
        i_frame_ready = rdy;
        acc = v && (pend.size() < 2);
        drn = (pend.size() > 0) && rdy;
        @(posedge sys_clk);
        if (v && !acc) exp_stall = 1'b1;
        if (drn) begin
            void'(pend.pop_front());
            exp_frame_cnt = (exp_frame_cnt + 1) % 65536;
        end
        if (acc) cur_syms.push_back(s);
        if (cur_syms.size() == SYMS || (fl && cur_syms.size() > 0)) begin
            pend.push_back(build_frame(SYMS - cur_syms.size()));
            cur_syms.delete();
        end
        @(negedge sys_clk);
        i_sym_valid = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        i_sym_valid   = 1'b0;
        i_flush       = 1'b0;
        i_frame_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        checks++; if (o_sym_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", o_sym_ready); end
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_frame_valid); end
        checks++; if (o_frame !== 16'h0000) begin errors++; $display("[TB] FAIL reset_frame: got %h expected 0000", o_frame); end
        checks++; if (o_pad_syms !== '0) begin errors++; $display("[TB] FAIL reset_pad: got %0d expected 0", o_pad_syms); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int syms[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (o_sym_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready[%0d]: got %b expected 1", i, o_sym_ready); end
            checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid[%0d]: got %b expected 0", i, o_frame_valid); end
            drive_cycle(1'b1, syms[i], 1'b0, 1'b1);
        end
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", o_frame_valid); end
        checks++; if (o_frame !== 16'hE4E4) begin errors++; $display("[TB] FAIL basic_frame: got %h expected e4e4", o_frame); end
        checks++; if (o_pad_syms !== '0) begin errors++; $display("[TB] FAIL basic_pad: got %0d expected 0", o_pad_syms); end
        drive_cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_pulse: got %b expected 0", o_frame_valid); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            checks++; if (o_sym_ready !== (pend.size() < 2)) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", i, o_sym_ready, pend.size() < 2); end
            if (o_sym_ready === 1'b1) accepted++;
            drive_cycle(1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        checks++; if (accepted != 16) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected 16", accepted); end
        checks++; if (o_sym_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b expected 0", o_sym_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_frame_valid !== 1'b1 || o_frame !== pend[0].frame) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got %b/%h expected 1/%h", i, o_frame_valid, o_frame, pend[0].frame); end
            drive_cycle(1'b0, 0, 1'b0, 1'b0);
        end
        for (int f = 0; f < 2; f++) begin
            checks++; if (o_frame_valid !== 1'b1 || o_frame !== pend[0].frame || o_pad_syms !== '0) begin errors++; $display("[TB] FAIL bp_drain[%0d]: got %b/%h/%0d expected 1/%h/0", f, o_frame_valid, o_frame, o_pad_syms, pend[0].frame); end
            drive_cycle(1'b0, 0, 1'b0, 1'b1);
            checks++; if (o_sym_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_rise[%0d]: got %b expected 1", f, o_sym_ready); end
        end
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b expected 0", o_frame_valid); end
    endtask

    task automatic test_partial_flush();
        apply_reset();
        for (int i = 1; i <= 3; i++) drive_cycle(1'b1, i, 1'b0, 1'b0);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL pf_premature: got %b expected 0", o_frame_valid); end
        drive_cycle(1'b0, 0, 1'b1, 1'b0);
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL pf_valid: got %b expected 1", o_frame_valid); end
        checks++; if (o_frame !== 16'h6C00) begin errors++; $display("[TB] FAIL pf_frame: got %h expected 6c00", o_frame); end
        checks++; if (o_pad_syms !== PAD_W'(5)) begin errors++; $display("[TB] FAIL pf_pad: got %0d expected 5", o_pad_syms); end
        drive_cycle(1'b0, 0, 1'b1, 1'b1);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL pf_empty_flush: got %b expected 0", o_frame_valid); end
        drive_cycle(1'b0, 0, 1'b1, 1'b1);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL pf_idle_flush: got %b expected 0", o_frame_valid); end
        drive_cycle(1'b1, 2, 1'b1, 1'b0);
        checks++; if (o_frame !== 16'h8000 || o_pad_syms !== PAD_W'(7)) begin errors++; $display("[TB] FAIL pf_single: got %h/%0d expected 8000/7", o_frame, o_pad_syms); end
    endtask

    task automatic test_flush_complete();
        apply_reset();
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        drive_cycle(1'b1, 1, 1'b1, 1'b0);
        checks++; if (o_frame_valid !== 1'b1 || o_pad_syms !== '0 || o_frame !== pend[0].frame) begin errors++; $display("[TB] FAIL fc_frame: got %b/%h/%0d expected 1/%h/0", o_frame_valid, o_frame, o_pad_syms, pend[0].frame); end
        drive_cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL fc_single: got %b expected 0", o_frame_valid); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (o_frame_valid !== 1'b0 || o_frame !== 16'h0000 || o_pad_syms !== '0) begin errors++; $display("[TB] FAIL rm_outputs: got %b/%h/%0d expected 0/0000/0", o_frame_valid, o_frame, o_pad_syms); end
        checks++; if (o_sym_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready: got %b expected 1", o_sym_ready); end
        model_clear();
        @(negedge sys_clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, i % 4, 1'b0, 1'b0);
        checks++; if (o_frame_valid !== 1'b1 || o_frame !== 16'h1B1B) begin errors++; $display("[TB] FAIL rm_new_frame: got %b/%h expected 1/1b1b", o_frame_valid, o_frame); end
        drive_cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_stale: got %b expected 0", o_frame_valid); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            checks++; if (o_sym_ready !== (pend.size() < 2)) begin errors++; $display("[TB] FAIL rnd_ready@%0d: got %b expected %b", c, o_sym_ready, pend.size() < 2); end
            checks++; if (o_frame_valid !== (pend.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", c, o_frame_valid, pend.size() > 0); end
            if (pend.size() > 0) begin
                checks++; if (o_frame !== pend[0].frame || o_pad_syms !== PAD_W'(pend[0].pad)) begin errors++; $display("[TB] FAIL rnd_frame@%0d: got %h/%0d expected %h/%0d", c, o_frame, o_pad_syms, pend[0].frame, pend[0].pad); end
            end
`ifdef RX_PACKER_STATS_EN
            checks++; if (o_frame_cnt !== 16'(exp_frame_cnt) || o_stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stats@%0d: got %0d/%b expected %0d/%b", c, o_frame_cnt, o_stall, exp_frame_cnt, exp_stall); end
`endif
            drive_cycle(($urandom % 4) != 0, int'($urandom_range(0, 3)), ($urandom % 8) == 0, ($urandom % 3) != 0);
        end
    endtask

`ifdef RX_PACKER_STATS_EN
    task automatic test_stats();
        apply_reset();
        checks++; if (o_frame_cnt !== 16'd0 || o_stall !== 1'b0) begin errors++; $display("[TB] FAIL st_reset: got %0d/%b expected 0/0", o_frame_cnt, o_stall); end
        for (int i = 0; i < 24; i++) drive_cycle(1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b1);
        drive_cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (o_frame_cnt !== 16'd3) begin errors++; $display("[TB] FAIL st_count: got %0d expected 3", o_frame_cnt); end
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1, 1'b0, 1'b0);
        checks++; if (o_stall !== 1'b0) begin errors++; $display("[TB] FAIL st_no_stall: got %b expected 0", o_stall); end
        drive_cycle(1'b1, 2, 1'b0, 1'b0);
        checks++; if (o_stall !== 1'b1) begin errors++; $display("[TB] FAIL st_stall: got %b expected 1", o_stall); end
        repeat (3) drive_cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (o_stall !== 1'b1 || o_frame_cnt !== 16'd5) begin errors++; $display("[TB] FAIL st_sticky: got %b/%0d expected 1/5", o_stall, o_frame_cnt); end
        apply_reset();
        checks++; if (o_stall !== 1'b0 || o_frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL st_cleared: got %b/%0d expected 0/0", o_stall, o_frame_cnt); end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        i_sym         = '0;
        i_sym_valid   = 1'b0;
        i_flush       = 1'b0;
        i_frame_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_partial_flush();
        test_flush_complete();
        test_reset_mid();
        test_random();
`ifdef RX_PACKER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
